piso_tx_scheduler: RTL and testbench
====================================

Name: piso_tx_scheduler

Overview:
- Round-robin scheduler that shares one `piso` serializer among NUM_REQ parallel-word requesters.
- Accepts one word per valid/ready handshake, drives the serializer's load/enable/parallel_in, and frames the serial bitstream with tx_active/tx_last/tx_id.
- Sits between the parallel-word producers and the `piso` instance, which is external; this block contains no serial shift register.
- The serializer is MSB-first, and load has priority over enable inside it.

Parameters:
- DATA_WIDTH, 8: word width; must match the `piso` instance.
- NUM_REQ, 4: number of requesters, 2..16.
- GAP_CYCLES, 0: idle cycles inserted after each frame's last bit, 0..255.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester word available
- req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot accept; combinational from state, pointer and req_valid
- piso_load  output  1  to piso.load
- piso_enable  output  1  to piso.enable
- piso_data  output  DATA_WIDTH  to piso.parallel_in, registered
- tx_active  output  1  high while piso.serial_out carries a valid frame bit
- tx_last  output  1  high during the final bit (LSB) of a frame
- tx_id  output  $clog2(NUM_REQ)  index of the requester owning the current frame
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, rr_ptr=0, bit_cnt=0, gap_cnt=0, piso_data=0, tx_id=0.
  - All 1-bit outputs are 0 and req_ready=0 during reset.
  - Reset mid-frame abandons the frame immediately; the word is lost and is not re-acknowledged.
- States are IDLE, LOAD, SHIFT and GAP.
- Arbitration window (ARB):
  - Open in IDLE, in SHIFT when bit_cnt=DATA_WIDTH-1 and GAP_CYCLES=0, and in GAP when gap_cnt=GAP_CYCLES-1.
  - Outside ARB, req_ready=0.
- Arbitration rule:
  - Winner g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle as the win; the handshake completes that cycle.
  - On the clock edge: piso_data<=req_data[g], tx_id<=g, rr_ptr<=(g+1) mod NUM_REQ, next state=LOAD.
  - If no request is valid in ARB: from IDLE stay in IDLE; from SHIFT or GAP go to IDLE. rr_ptr is unchanged.
- LOAD (1 cycle):
  - piso_load=1, piso_enable=0, busy=1; next state SHIFT with bit_cnt=0.
  - The piso captures piso_data at the end of this cycle.
- SHIFT (DATA_WIDTH cycles, bit_cnt 0..DATA_WIDTH-1):
  - tx_active=1 and piso_enable=1 every cycle.
  - piso.serial_out equals piso_data[DATA_WIDTH-1-bit_cnt].
  - tx_last=1 when bit_cnt=DATA_WIDTH-1.
  - After the last bit: ARB if GAP_CYCLES=0, otherwise go to GAP with gap_cnt=0.
  - A LOAD issued straight after the last bit overrides that cycle's shift, because load wins inside the piso.
- GAP (GAP_CYCLES cycles): tx_active=0, piso_enable=0, busy=1; ARB is open in the final GAP cycle.
- Latency: handshake cycle T gives piso_load at T+1 and the first bit (MSB, tx_active=1) at T+2.
- Frame period under continuous traffic is DATA_WIDTH+1+GAP_CYCLES cycles.
  - tx_active therefore drops for at least 1 cycle (the LOAD cycle) between frames.
- piso_data and tx_id hold their values until the next grant.
- req_valid deasserting when not granted is legal; no request is queued internally.
- busy=0 only in IDLE.
- Counter widths: bit_cnt is $clog2(DATA_WIDTH) bits; gap_cnt is 8 bits. Neither counter wraps within a legal sequence.

Test Plan (NUM_REQ=4, DATA_WIDTH=8):
1. Single word, GAP=0: req_valid=0001 and req_data[0]=0xA5 from cycle 5.
   - req_ready=0001 at cycle 5 and piso_load at cycle 6.
   - serial_out over cycles 7..14 = 1,0,1,0,0,1,0,1; tx_last at cycle 14 only; tx_id=0; IDLE and busy=0 at cycle 15.
2. Round robin, GAP=0: all four req_valid held high with distinct words.
   - Grants run 0,1,2,3,0 with a period of 9 cycles.
   - tx_id follows the grant order; each req_ready is a single-cycle pulse.
3. Fairness: req_valid held at 1010.
   - Grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
4. Gap, GAP=2: req_valid=0100 held.
   - Frame period is 11 cycles; tx_active and piso_enable are 0 for the 2 gap cycles plus the LOAD cycle.
5. Reset mid-frame: rstn=0 for 1 cycle at bit_cnt=3.
   - Next cycle: all outputs 0 and rr_ptr=0.
   - With 1111 pending, the next grant goes to requester 0.
6. Drop in window: req_valid[2] pulses only during a non-ARB SHIFT cycle.
   - No req_ready, and no frame is issued for requester 2.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one external MSB-first piso serializer.
// Issues load/enable/parallel data and frames the serial bits with tx_active/tx_last/tx_id.
module piso_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          piso_load,
  output logic                          piso_enable,
  output logic [DATA_WIDTH-1:0]         piso_data,
  output logic                          tx_active,
  output logic                          tx_last,
  output logic [$clog2(NUM_REQ)-1:0]    tx_id,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BW   = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr, ptr_next, id_next;
  logic [BW-1:0]   bit_cnt, bit_next;
  logic [7:0]      gap_cnt, gap_next;
  logic [DATA_WIDTH-1:0] data_next;

  logic                  found;
  logic [ID_W-1:0]       gnt_id, gnt_ptr;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  arb_open;

  // Rotating search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    found    = 1'b0;
    gnt_id   = '0;
    gnt_ptr  = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_ptr  = (idx == NUM_REQ - 1) ? '0 : ID_W'(idx + 1);
        gnt_data = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    gap_next   = gap_cnt;
    ptr_next   = rr_ptr;
    data_next  = piso_data;
    id_next    = tx_id;
    arb_open   = 1'b0;
    req_ready  = '0;

    case (state)
      IDLE: arb_open = 1'b1;
      LOAD: begin
        state_next = SHIFT;
        bit_next   = '0;
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          if (GAP_CYCLES == 0) begin
            arb_open = 1'b1;
          end else begin
            state_next = GAP;
            gap_next   = '0;
          end
        end else begin
          bit_next = bit_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) arb_open = 1'b1;
        else                     gap_next = gap_cnt + 8'd1;
      end
      default: state_next = IDLE;
    endcase

    // A grant on the final bit issues LOAD next cycle; the piso's load priority overrides that shift.
    if (arb_open) begin
      if (found) begin
        state_next = LOAD;
        ptr_next   = gnt_ptr;
        data_next  = gnt_data;
        id_next    = gnt_id;
        if (rstn) req_ready[gnt_id] = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      piso_data <= '0;
      tx_id     <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= ptr_next;
      bit_cnt   <= bit_next;
      gap_cnt   <= gap_next;
      piso_data <= data_next;
      tx_id     <= id_next;
    end
  end

  assign piso_load   = rstn && (state == LOAD);
  assign piso_enable = rstn && (state == SHIFT);
  assign tx_active   = rstn && (state == SHIFT);
  assign tx_last     = rstn && (state == SHIFT) && (bit_cnt == BIT_LAST);
  assign busy        = rstn && (state != IDLE);

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler: one instance with no gap, one with a 2-cycle gap,
// each driving a behavioural MSB-first piso so the framed serial bits can be checked.
module tb_piso_tx_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data;
  logic [7:0]  word [4];

  logic [3:0] ready0, ready2;
  logic       load0, load2, en0, en2, act0, act2, last0, last2, busy0, busy2;
  logic [7:0] data0, data2;
  logic [1:0] id0, id2;
  logic [7:0] sr0, sr2;

  logic sel = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  initial begin
    word[0] = 8'hA5; word[1] = 8'h3C; word[2] = 8'h96; word[3] = 8'hE1;
  end
  assign req_data = {word[3], word[2], word[1], word[0]};

  piso_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready0), .piso_load(load0), .piso_enable(en0), .piso_data(data0),
    .tx_active(act0), .tx_last(last0), .tx_id(id0), .busy(busy0));

  piso_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready2), .piso_load(load2), .piso_enable(en2), .piso_data(data2),
    .tx_active(act2), .tx_last(last2), .tx_id(id2), .busy(busy2));

  // Behavioural serializers: load wins over enable, shift towards MSB.
  always @(posedge clk) begin
    if (load0) sr0 <= data0;
    else if (en0) sr0 <= {sr0[6:0], 1'b0};
    if (load2) sr2 <= data2;
    else if (en2) sr2 <= {sr2[6:0], 1'b0};
  end

  wire [3:0] o_ready  = sel ? ready2 : ready0;
  wire       o_load   = sel ? load2  : load0;
  wire       o_en     = sel ? en2    : en0;
  wire       o_act    = sel ? act2   : act0;
  wire       o_last   = sel ? last2  : last0;
  wire       o_busy   = sel ? busy2  : busy0;
  wire [7:0] o_data   = sel ? data2  : data0;
  wire [1:0] o_id     = sel ? id2    : id0;
  wire       o_serial = sel ? sr2[7] : sr0[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rstn = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", {28'd0, o_ready}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_load", {31'd0, o_load}, 0);
    chk("rst_active", {31'd0, o_act}, 0);
    cyc();
    rstn = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("rst_data", {24'd0, o_data}, 0);
    chk("rst_id", {30'd0, o_id}, 0);
    chk("rst_busy2", {31'd0, o_busy}, 0);
  endtask

  // Called the cycle after a grant to id; checks LOAD, the 8 bits, and any gap.
  // nxt is the requester expected to win in the next window, or -1 for none.
  task automatic frame(input int id, input logic [3:0] v_during, input int nxt);
    logic [7:0] w;
    logic [3:0] exp_rdy;
    w = word[id];
    exp_rdy = (nxt < 0) ? 4'b0000 : 4'(1 << nxt);
    cyc();
    req_valid = v_during;
    #1;
    chk("load", {31'd0, o_load}, 1);
    chk("load_en", {31'd0, o_en}, 0);
    chk("load_id", {30'd0, o_id}, 32'(id));
    chk("load_data", {24'd0, o_data}, {24'd0, w});
    chk("load_ready", {28'd0, o_ready}, 0);
    for (int b = 0; b < 8; b++) begin
      cyc();
      #1;
      chk("active", {31'd0, o_act}, 1);
      chk("serial", {31'd0, o_serial}, {31'd0, w[7-b]});
      chk("last", {31'd0, o_last}, (b == 7) ? 1 : 0);
      chk("shift_ready", {28'd0, o_ready}, (b == 7 && !sel) ? {28'd0, exp_rdy} : 0);
    end
    if (sel) begin
      for (int g = 0; g < 2; g++) begin
        cyc();
        #1;
        chk("gap_active", {31'd0, o_act}, 0);
        chk("gap_en", {31'd0, o_en}, 0);
        chk("gap_busy", {31'd0, o_busy}, 1);
        chk("gap_ready", {28'd0, o_ready}, (g == 1) ? {28'd0, exp_rdy} : 0);
      end
    end
  endtask

  task automatic idle_check();
    cyc();
    #1;
    chk("idle_busy", {31'd0, o_busy}, 0);
    chk("idle_active", {31'd0, o_act}, 0);
    chk("idle_load", {31'd0, o_load}, 0);
  endtask

  initial begin
    // single word from requester 0
    do_reset();
    cyc(); req_valid = 4'b0001; #1;
    chk("t1_ready", {28'd0, o_ready}, 32'b0001);
    chk("t1_busy", {31'd0, o_busy}, 0);
    frame(0, 4'b0000, -1);
    idle_check();

    // round robin across all four requesters
    do_reset();
    cyc(); req_valid = 4'b1111; #1;
    chk("t2_ready", {28'd0, o_ready}, 32'b0001);
    frame(0, 4'b1111, 1);
    frame(1, 4'b1111, 2);
    frame(2, 4'b1111, 3);
    frame(3, 4'b1111, 0);
    frame(0, 4'b0000, -1);
    idle_check();

    // fairness with requesters 1 and 3 (pointer now at 1)
    cyc(); req_valid = 4'b1010; #1;
    chk("t3_ready", {28'd0, o_ready}, 32'b0010);
    frame(1, 4'b1010, 3);
    frame(3, 4'b1010, 1);
    frame(1, 4'b1010, 3);
    frame(3, 4'b0000, -1);
    idle_check();

    // two-cycle gap instance
    sel = 1'b1;
    do_reset();
    cyc(); req_valid = 4'b0100; #1;
    chk("t4_ready", {28'd0, o_ready}, 32'b0100);
    frame(2, 4'b0100, 2);
    frame(2, 4'b0100, 2);
    frame(2, 4'b0000, -1);
    idle_check();

    // reset in the middle of a frame
    sel = 1'b0;
    do_reset();
    cyc(); req_valid = 4'b0010; #1;
    chk("t5_ready", {28'd0, o_ready}, 32'b0010);
    cyc(); req_valid = 4'b1111; #1;
    chk("t5_load", {31'd0, o_load}, 1);
    for (int b = 0; b < 3; b++) begin
      cyc(); #1;
      chk("t5_serial", {31'd0, o_serial}, {31'd0, word[1][7-b]});
    end
    cyc(); rstn = 1'b0; #1;
    chk("t5_rst_active", {31'd0, o_act}, 0);
    chk("t5_rst_ready", {28'd0, o_ready}, 0);
    chk("t5_rst_busy", {31'd0, o_busy}, 0);
    cyc(); rstn = 1'b1; #1;
    chk("t5_post_busy", {31'd0, o_busy}, 0);
    chk("t5_post_active", {31'd0, o_act}, 0);
    chk("t5_post_data", {24'd0, o_data}, 0);
    chk("t5_post_id", {30'd0, o_id}, 0);
    chk("t5_post_ready", {28'd0, o_ready}, 32'b0001);
    frame(0, 4'b0000, -1);
    idle_check();

    // request pulse outside the arbitration window is ignored
    cyc(); req_valid = 4'b0001; #1;
    chk("t6_ready", {28'd0, o_ready}, 32'b0001);
    cyc(); req_valid = 4'b0000; #1;
    chk("t6_load", {31'd0, o_load}, 1);
    for (int b = 0; b < 8; b++) begin
      cyc();
      req_valid = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      chk("t6_ready_shift", {28'd0, o_ready}, 0);
      chk("t6_serial", {31'd0, o_serial}, {31'd0, word[0][7-b]});
    end
    idle_check();
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
